// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 command receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } frame_state_t;

    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_ESC   = 8'h76;

endpackage

// File: rtl/ps2_filter.sv
// Pin synchronisers plus a stability filter on PS/2 clock that yields a
// one-cycle strobe on each accepted falling edge.
module ps2_filter #(
    parameter int FLT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_fall,
    output logic dat_sync
);

    localparam int CW = $clog2(FLT + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_pipe;
    logic [CW-1:0] cnt;
    logic          clk_flt;

    // A new level is accepted only after FLT consecutive cycles of disagreement
    // with the current filtered level; any return to the old level restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_pipe <= 2'b11;
            cnt      <= '0;
            clk_flt  <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_pipe <= {dat_pipe[0], ps2_dat};
            clk_fall <= 1'b0;
            if (clk_sync[1] == clk_flt) begin
                cnt <= '0;
            end else if (cnt == CW'(FLT - 1)) begin
                cnt      <= '0;
                clk_flt  <= clk_sync[1];
                clk_fall <= ~clk_sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dat_sync = dat_pipe[1];

endmodule

// File: rtl/ps2_command_rx.sv
// PS/2 device-to-host deframer with scan-code-set-2 decoding into
// run/clear/reset command pulses for the stopwatch.
module ps2_command_rx
    import ps2_pkg::*;
#(
    parameter int FRQ  = 24000000,
    parameter int FLT  = 8,
    parameter int TOUT = FRQ / 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    output logic       rx_err,
    output logic       c_run,
    output logic       c_clr,
    output logic       c_rst,
    output logic       s_brk,
    output logic       s_ext
);

    localparam int TW = $clog2(TOUT + 1);

    logic          fall;
    logic          dat;
    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;

    ps2_filter #(.FLT(FLT)) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .clk_fall (fall),
        .dat_sync (dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
            rx_dat  <= '0;
            rx_vld  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            rx_vld <= 1'b0;
            rx_err <= 1'b0;
            if (state == IDLE || fall) to_cnt <= '0;
            else                       to_cnt <= to_cnt + 1'b1;

            if (fall) begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        if (!dat) state <= DATA;
                    end
                    DATA: begin
                        shreg   <= {dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PAR;
                    end
                    PAR: begin
                        par   <= dat;
                        state <= STOP;
                    end
                    STOP: begin
                        // Odd parity across data plus parity bit.
                        if (dat && ^{shreg, par}) begin
                            rx_vld <= 1'b1;
                            rx_dat <= shreg;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && to_cnt == TW'(TOUT)) begin
                state   <= IDLE;
                bit_cnt <= '0;
                shreg   <= '0;
            end
        end
    end

    // Prefix bytes arm s_brk/s_ext; the following byte consumes them and only
    // issues a command when no prefix was pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_run <= 1'b0;
            c_clr <= 1'b0;
            c_rst <= 1'b0;
            s_brk <= 1'b0;
            s_ext <= 1'b0;
        end else begin
            c_run <= 1'b0;
            c_clr <= 1'b0;
            c_rst <= 1'b0;
            if (rx_err) begin
                s_brk <= 1'b0;
                s_ext <= 1'b0;
            end else if (rx_vld) begin
                if (rx_dat == SC_BRK) begin
                    s_brk <= 1'b1;
                end else if (rx_dat == SC_EXT) begin
                    s_ext <= 1'b1;
                end else begin
                    if (!s_brk && !s_ext) begin
                        c_run <= (rx_dat == SC_SPACE) || (rx_dat == SC_R);
                        c_clr <= (rx_dat == SC_C);
                        c_rst <= (rx_dat == SC_ESC);
                    end
                    s_brk <= 1'b0;
                    s_ext <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_command_rx.sv
// Directed bench for ps2_command_rx: drives PS/2 frames bit by bit and checks
// received bytes, error pulses, command pulses and prefix levels.
module tb_ps2_command_rx;

    localparam int HALF = 40;   // PS/2 half period in clk cycles
    localparam int TOUT = 400;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] rx_dat;
    logic       rx_vld, rx_err, c_run, c_clr, c_rst, s_brk, s_ext;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor totals, only written by the monitor process.
    int vld_cnt = 0, err_cnt = 0, run_cnt = 0, clr_cnt = 0, rst_cnt = 0;
    int misalign = 0;
    logic prev_vld = 1'b0;

    // Snapshots, only written by the stimulus process.
    int v0, e0, r0, c0, x0, m0;

    ps2_command_rx #(.FRQ(2000000), .FLT(8), .TOUT(TOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .rx_dat  (rx_dat),
        .rx_vld  (rx_vld),
        .rx_err  (rx_err),
        .c_run   (c_run),
        .c_clr   (c_clr),
        .c_rst   (c_rst),
        .s_brk   (s_brk),
        .s_ext   (s_ext)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rx_vld) vld_cnt++;
        if (rx_err) err_cnt++;
        if (c_run)  run_cnt++;
        if (c_clr)  clr_cnt++;
        if (c_rst)  rst_cnt++;
        if ((c_run || c_clr || c_rst) && !prev_vld) misalign++;
        prev_vld = rx_vld;
    end

    // ---------------- drivers ----------------
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip);
        logic p;
        p = ~(^d) ^ flip;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive frame bits [first..last]; optional short glitches on ps2_clk.
    task automatic send_bits(input logic [10:0] f, input int first, input int last,
                             input bit glitch);
        for (int i = first; i <= last; i++) begin
            ps2_dat = f[i];
            if (glitch) begin
                wait_clk(10); ps2_clk = 1'b0;
                wait_clk(2);  ps2_clk = 1'b1;
                wait_clk(HALF - 12);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b0;
            if (glitch) begin
                wait_clk(15); ps2_clk = 1'b1;
                wait_clk(2);  ps2_clk = 1'b0;
                wait_clk(HALF - 17);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic flip);
        send_bits(mk_frame(d, flip), 0, 10, 1'b0);
        wait_clk(30);
    endtask

    task automatic snap();
        v0 = vld_cnt; e0 = err_cnt; r0 = run_cnt;
        c0 = clr_cnt; x0 = rst_cnt; m0 = misalign;
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(20);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rst_n   = 1'b0;
        wait_clk(3);
        @(negedge clk);
        n_checks++;
        if (rx_dat !== 8'h00) $display("FAIL reset_rx_dat: got %h exp 00", rx_dat);
        else n_pass++;
        n_checks++;
        if ({rx_vld, rx_err} !== 2'b00) $display("FAIL reset_vld_err: got %b exp 00", {rx_vld, rx_err});
        else n_pass++;
        n_checks++;
        if ({c_run, c_clr, c_rst, s_brk, s_ext} !== 5'b0)
            $display("FAIL reset_cmd_state: got %b exp 00000", {c_run, c_clr, c_rst, s_brk, s_ext});
        else n_pass++;
        rst_n = 1'b1;
        wait_clk(20);
    endtask

    task automatic test_good_frame();
        snap();
        send_byte(8'h2D, 1'b0);
        n_checks++;
        if (vld_cnt - v0 !== 1) $display("FAIL good_vld: got %0d exp 1", vld_cnt - v0);
        else n_pass++;
        n_checks++;
        if (rx_dat !== 8'h2D) $display("FAIL good_dat: got %h exp 2d", rx_dat);
        else n_pass++;
        n_checks++;
        if (run_cnt - r0 !== 1) $display("FAIL good_run: got %0d exp 1", run_cnt - r0);
        else n_pass++;
        n_checks++;
        if (err_cnt - e0 !== 0) $display("FAIL good_err: got %0d exp 0", err_cnt - e0);
        else n_pass++;
        n_checks++;
        if (misalign - m0 !== 0) $display("FAIL good_cmd_timing: got %0d late pulses exp 0", misalign - m0);
        else n_pass++;
    endtask

    task automatic test_parity_err();
        snap();
        send_byte(8'h21, 1'b1);
        n_checks++;
        if (err_cnt - e0 !== 1) $display("FAIL par_err: got %0d exp 1", err_cnt - e0);
        else n_pass++;
        n_checks++;
        if (vld_cnt - v0 !== 0) $display("FAIL par_vld: got %0d exp 0", vld_cnt - v0);
        else n_pass++;
        n_checks++;
        if (rx_dat !== 8'h2D) $display("FAIL par_dat_held: got %h exp 2d", rx_dat);
        else n_pass++;
        n_checks++;
        if (clr_cnt - c0 !== 0) $display("FAIL par_clr: got %0d exp 0", clr_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_break();
        snap();
        send_byte(8'h76, 1'b0);
        send_byte(8'hF0, 1'b0);
        n_checks++;
        if (s_brk !== 1'b1) $display("FAIL brk_pending: got %b exp 1", s_brk);
        else n_pass++;
        send_byte(8'h76, 1'b0);
        n_checks++;
        if (rst_cnt - x0 !== 1) $display("FAIL brk_rst_count: got %0d exp 1", rst_cnt - x0);
        else n_pass++;
        n_checks++;
        if (s_brk !== 1'b0) $display("FAIL brk_cleared: got %b exp 0", s_brk);
        else n_pass++;
        n_checks++;
        if (vld_cnt - v0 !== 3) $display("FAIL brk_vld: got %0d exp 3", vld_cnt - v0);
        else n_pass++;
    endtask

    task automatic test_ext();
        snap();
        send_byte(8'hE0, 1'b0);
        n_checks++;
        if (s_ext !== 1'b1) $display("FAIL ext_pending: got %b exp 1", s_ext);
        else n_pass++;
        send_byte(8'h29, 1'b0);
        n_checks++;
        if (vld_cnt - v0 !== 2) $display("FAIL ext_vld: got %0d exp 2", vld_cnt - v0);
        else n_pass++;
        n_checks++;
        if (run_cnt - r0 !== 0) $display("FAIL ext_run: got %0d exp 0", run_cnt - r0);
        else n_pass++;
        n_checks++;
        if (s_ext !== 1'b0) $display("FAIL ext_cleared: got %b exp 0", s_ext);
        else n_pass++;
    endtask

    task automatic test_timeout();
        snap();
        send_bits(mk_frame(8'h21, 1'b0), 0, 4, 1'b0);
        wait_clk(TOUT + 200);
        n_checks++;
        if ((vld_cnt - v0) + (err_cnt - e0) !== 0)
            $display("FAIL tout_silent: got %0d outputs exp 0", (vld_cnt - v0) + (err_cnt - e0));
        else n_pass++;
        send_byte(8'h21, 1'b0);
        n_checks++;
        if (clr_cnt - c0 !== 1) $display("FAIL tout_clr: got %0d exp 1", clr_cnt - c0);
        else n_pass++;
        n_checks++;
        if (rx_dat !== 8'h21) $display("FAIL tout_dat: got %h exp 21", rx_dat);
        else n_pass++;
        n_checks++;
        if (err_cnt - e0 !== 0) $display("FAIL tout_err: got %0d exp 0", err_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_glitch();
        snap();
        send_bits(mk_frame(8'h29, 1'b0), 0, 10, 1'b1);
        wait_clk(30);
        n_checks++;
        if (rx_dat !== 8'h29) $display("FAIL glitch_dat: got %h exp 29", rx_dat);
        else n_pass++;
        n_checks++;
        if (vld_cnt - v0 !== 1) $display("FAIL glitch_vld: got %0d exp 1", vld_cnt - v0);
        else n_pass++;
        n_checks++;
        if (run_cnt - r0 !== 1) $display("FAIL glitch_run: got %0d exp 1", run_cnt - r0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] f;
        f = mk_frame(8'h29, 1'b0);
        snap();
        send_bits(f, 0, 4, 1'b0);
        do_reset();
        send_bits(f, 5, 10, 1'b0);
        wait_clk(TOUT + 200);
        n_checks++;
        if ((vld_cnt - v0) + (err_cnt - e0) !== 0)
            $display("FAIL rstmid_silent: got %0d outputs exp 0", (vld_cnt - v0) + (err_cnt - e0));
        else n_pass++;
        n_checks++;
        if (rx_dat !== 8'h00) $display("FAIL rstmid_dat: got %h exp 00", rx_dat);
        else n_pass++;
        n_checks++;
        if (run_cnt - r0 !== 0) $display("FAIL rstmid_run: got %0d exp 0", run_cnt - r0);
        else n_pass++;
        send_byte(8'h76, 1'b0);
        n_checks++;
        if (rst_cnt - x0 !== 1) $display("FAIL rstmid_next_rst: got %0d exp 1", rst_cnt - x0);
        else n_pass++;
        n_checks++;
        if (rx_dat !== 8'h76) $display("FAIL rstmid_next_dat: got %h exp 76", rx_dat);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        snap();
        send_byte(8'h2D, 1'b0);
        send_byte(8'h2D, 1'b0);
        send_byte(8'h33, 1'b0);
        n_checks++;
        if (run_cnt - r0 !== 2) $display("FAIL b2b_repeat_run: got %0d exp 2", run_cnt - r0);
        else n_pass++;
        n_checks++;
        if (rx_dat !== 8'h33) $display("FAIL b2b_unlisted_dat: got %h exp 33", rx_dat);
        else n_pass++;
        n_checks++;
        if ((clr_cnt - c0) + (rst_cnt - x0) !== 0)
            $display("FAIL b2b_other_cmds: got %0d exp 0", (clr_cnt - c0) + (rst_cnt - x0));
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_break();
        test_ext();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
